// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// No logic here; pure declarations and a clamp helper.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t cen;
        bcd_t dez;
        bcd_t uni;
        bcd_t dec;
    } digits_t;

    localparam bcd_t BCD_MAX          = 4'd9;
    localparam int   TICK_DIV_DEFAULT = 5000000;

    function automatic bcd_t bcd_clamp(input bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Purpose: prescaler counting 0..DIV-1 while enabled, one-cycle tick on wrap.
// Latency: tick is combinational from the registered count; count updates each enabled edge.
// Backpressure: none; en low holds the count, clr zeroes it and overrides en.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Purpose: four-digit BCD countdown with load/start/pause/clear commands, alarm and display blink.
// Latency: all outputs registered; a command is visible one cycle after its pulse.
// Backpressure: none; commands are single-cycle pulses, unsupported ones are dropped.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV    = TICK_DIV_DEFAULT,
    parameter int BLINK_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_load,
    input  logic       cmd_start,
    input  logic       cmd_pause,
    input  logic       cmd_clear,
    input  logic [3:0] preset_cen,
    input  logic [3:0] preset_dez,
    input  logic [3:0] preset_uni,
    input  logic [3:0] preset_dec,
    output logic [3:0] centena,
    output logic [3:0] dezena,
    output logic [3:0] unidade,
    output logic [3:0] decimo,
    output logic       display_en,
    output logic       running,
    output logic       alarm,
    output logic       done_pulse
);

    localparam int BW = $clog2(BLINK_TICKS + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    state_t        state, state_nxt;
    digits_t       dig, dig_nxt, dig_dec, preset;
    logic          tick, presc_en, presc_clr, done_nxt;
    logic          is_zero, is_last;
    logic [BW-1:0] blink_cnt;

    assign preset  = {bcd_clamp(preset_cen), bcd_clamp(preset_dez),
                      bcd_clamp(preset_uni), bcd_clamp(preset_dec)};
    assign is_zero = (dig == '0);
    assign is_last = (dig.cen == '0) && (dig.dez == '0) && (dig.uni == '0) && (dig.dec == 4'd1);

    // The prescaler also runs in DONE so its ticks can pace the blink.
    assign presc_en = (state == ST_RUN) || (state == ST_DONE);

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (presc_en),
        .clr   (presc_clr),
        .tick  (tick)
    );

    always_comb begin
        dig_dec = dig;
        if (dig.dec != '0) begin
            dig_dec.dec = dig.dec - 4'd1;
        end else begin
            dig_dec.dec = BCD_MAX;
            if (dig.uni != '0) begin
                dig_dec.uni = dig.uni - 4'd1;
            end else begin
                dig_dec.uni = BCD_MAX;
                if (dig.dez != '0) begin
                    dig_dec.dez = dig.dez - 4'd1;
                end else begin
                    dig_dec.dez = BCD_MAX;
                    dig_dec.cen = dig.cen - 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        dig_nxt   = dig;
        presc_clr = 1'b0;
        done_nxt  = 1'b0;
        if (cmd_clear) begin
            dig_nxt   = '0;
            presc_clr = 1'b1;
            state_nxt = ST_IDLE;
        end else if (cmd_load && (state != ST_RUN)) begin
            dig_nxt   = preset;
            presc_clr = 1'b1;
            state_nxt = ST_IDLE;
        end else if (cmd_start && ((state == ST_IDLE) || (state == ST_PAUSE))) begin
            if (!is_zero) begin
                state_nxt = ST_RUN;
                // Resuming from PAUSE keeps the elapsed prescaler cycles.
                presc_clr = (state == ST_IDLE);
            end
        end else if (state == ST_RUN) begin
            if (tick) begin
                if (is_last) begin
                    dig_nxt   = '0;
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                end else begin
                    dig_nxt = dig_dec;
                end
            end
            if (cmd_pause && !(tick && is_last)) begin
                state_nxt = ST_PAUSE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            dig        <= '0;
            running    <= 1'b0;
            alarm      <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            dig        <= dig_nxt;
            running    <= (state_nxt == ST_RUN);
            alarm      <= (state_nxt == ST_DONE);
            done_pulse <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt  <= '0;
            display_en <= 1'b1;
        end else if (state_nxt != ST_DONE) begin
            blink_cnt  <= '0;
            display_en <= 1'b1;
        end else if ((state == ST_DONE) && tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt  <= '0;
                display_en <= ~display_en;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign centena = dig.cen;
    assign dezena  = dig.dez;
    assign unidade = dig.uni;
    assign decimo  = dig.dec;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer with TICK_DIV=4, BLINK_TICKS=2: vector table plus reset sequences.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_load = 1'b0, cmd_start = 1'b0, cmd_pause = 1'b0, cmd_clear = 1'b0;
    logic [3:0] preset_cen = '0, preset_dez = '0, preset_uni = '0, preset_dec = '0;
    logic [3:0] centena, dezena, unidade, decimo;
    logic       display_en, running, alarm, done_pulse;

    always #5 clk = ~clk;

    countdown_timer #(
        .TICK_DIV    (4),
        .BLINK_TICKS (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_load   (cmd_load),
        .cmd_start  (cmd_start),
        .cmd_pause  (cmd_pause),
        .cmd_clear  (cmd_clear),
        .preset_cen (preset_cen),
        .preset_dez (preset_dez),
        .preset_uni (preset_uni),
        .preset_dec (preset_dec),
        .centena    (centena),
        .dezena     (dezena),
        .unidade    (unidade),
        .decimo     (decimo),
        .display_en (display_en),
        .running    (running),
        .alarm      (alarm),
        .done_pulse (done_pulse)
    );

    // Observation word: digits, running, alarm, display_en, done_pulse.
    typedef struct packed {
        logic [15:0] dig;
        logic        run;
        logic        alm;
        logic        den;
        logic        dp;
    } obs_t;

    typedef struct {
        logic [3:0]  cmd;   // {clear, load, start, pause}
        logic [15:0] pre;
        int          w;     // extra edges after the command edge before sampling
        obs_t        exp;
    } vec_t;

    localparam logic [3:0] NOP = 4'b0000, PS = 4'b0001, ST = 4'b0010, LD = 4'b0100, CL = 4'b1000;
    localparam logic [3:0] F_IDLE = 4'b0010, F_RUN = 4'b1010, F_DONE = 4'b0110;
    localparam logic [3:0] F_DPUL = 4'b0111, F_DOFF = 4'b0100;

    obs_t sb[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic [3:0] cmd, input logic [15:0] pre, input int w,
                                input logic [15:0] dig, input logic [3:0] fl);
        vec_t v;
        v.cmd = cmd;
        v.pre = pre;
        v.w   = w;
        v.exp = {dig, fl};
        return v;
    endfunction

    task automatic check(input string name);
        obs_t e, o;
        o = {centena, dezena, unidade, decimo, running, alarm, display_en, done_pulse};
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, got dig=%h", name, o.dig);
        end else begin
            e = sb.pop_front();
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s: got dig=%h run=%b alarm=%b den=%b dp=%b, want dig=%h run=%b alarm=%b den=%b dp=%b",
                         name, o.dig, o.run, o.alm, o.den, o.dp, e.dig, e.run, e.alm, e.den, e.dp);
            end
        end
    endtask

    task automatic run_row(input vec_t v, input string name);
        {cmd_clear, cmd_load, cmd_start, cmd_pause} = v.cmd;
        {preset_cen, preset_dez, preset_uni, preset_dec} = v.pre;
        sb.push_back(v.exp);
        @(posedge clk);
        #1;
        {cmd_clear, cmd_load, cmd_start, cmd_pause} = 4'b0000;
        repeat (v.w) @(posedge clk);
        @(negedge clk);
        check(name);
    endtask

    // Assert reset between edges and check outputs before any clock edge arrives.
    task automatic async_reset_check(input string name);
        obs_t e;
        e = {16'h0000, F_IDLE};
        sb.push_back(e);
        #2;
        rst_n = 1'b0;
        #1;
        check(name);
        @(negedge clk);
        rst_n = 1'b1;
        e = {16'h0000, F_IDLE};
        sb.push_back(e);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check({name, "_release"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t e;

        #1 rst_n = 1'b0;
        #2;
        e = {16'h0000, F_IDLE};
        sb.push_back(e);
        check("reset_values");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        vecs.push_back(mk(LD,      16'h0003, 0,  16'h0003, F_IDLE));
        vecs.push_back(mk(ST,      16'h0000, 0,  16'h0003, F_RUN));
        vecs.push_back(mk(NOP,     16'h0000, 3,  16'h0002, F_RUN));
        vecs.push_back(mk(NOP,     16'h0000, 3,  16'h0001, F_RUN));
        vecs.push_back(mk(NOP,     16'h0000, 2,  16'h0001, F_RUN));
        vecs.push_back(mk(NOP,     16'h0000, 0,  16'h0000, F_DPUL));
        vecs.push_back(mk(NOP,     16'h0000, 0,  16'h0000, F_DONE));
        vecs.push_back(mk(NOP,     16'h0000, 5,  16'h0000, F_DONE));
        vecs.push_back(mk(NOP,     16'h0000, 0,  16'h0000, F_DOFF));
        vecs.push_back(mk(NOP,     16'h0000, 7,  16'h0000, F_DONE));
        vecs.push_back(mk(ST,      16'h0000, 0,  16'h0000, F_DONE));
        vecs.push_back(mk(LD,      16'h0100, 0,  16'h0100, F_IDLE));
        vecs.push_back(mk(ST,      16'h0000, 0,  16'h0100, F_RUN));
        vecs.push_back(mk(NOP,     16'h0000, 3,  16'h0099, F_RUN));
        vecs.push_back(mk(LD,      16'h0500, 0,  16'h0099, F_RUN));
        vecs.push_back(mk(NOP,     16'h0000, 2,  16'h0098, F_RUN));
        vecs.push_back(mk(CL | ST, 16'h0000, 0,  16'h0000, F_IDLE));
        vecs.push_back(mk(LD,      16'h1000, 0,  16'h1000, F_IDLE));
        vecs.push_back(mk(ST,      16'h0000, 0,  16'h1000, F_RUN));
        vecs.push_back(mk(NOP,     16'h0000, 3,  16'h0999, F_RUN));
        vecs.push_back(mk(CL,      16'h0000, 0,  16'h0000, F_IDLE));
        vecs.push_back(mk(LD,      16'h0C2F, 0,  16'h0929, F_IDLE));
        vecs.push_back(mk(CL,      16'h0000, 0,  16'h0000, F_IDLE));
        vecs.push_back(mk(ST,      16'h0000, 2,  16'h0000, F_IDLE));
        vecs.push_back(mk(LD,      16'h0005, 0,  16'h0005, F_IDLE));
        vecs.push_back(mk(ST,      16'h0000, 0,  16'h0005, F_RUN));
        vecs.push_back(mk(NOP,     16'h0000, 0,  16'h0005, F_RUN));
        vecs.push_back(mk(PS,      16'h0000, 0,  16'h0005, F_IDLE));
        vecs.push_back(mk(NOP,     16'h0000, 19, 16'h0005, F_IDLE));
        vecs.push_back(mk(ST,      16'h0000, 0,  16'h0005, F_RUN));
        vecs.push_back(mk(NOP,     16'h0000, 0,  16'h0005, F_RUN));
        vecs.push_back(mk(NOP,     16'h0000, 0,  16'h0004, F_RUN));
        vecs.push_back(mk(NOP,     16'h0000, 3,  16'h0003, F_RUN));

        for (int i = 0; i < vecs.size(); i++) begin
            run_row(vecs[i], $sformatf("row%0d", i));
        end

        async_reset_check("reset_mid_count");

        run_row(mk(LD,  16'h0001, 0, 16'h0001, F_IDLE), "done_load");
        run_row(mk(ST,  16'h0000, 3, 16'h0001, F_RUN),  "done_start");
        run_row(mk(NOP, 16'h0000, 0, 16'h0000, F_DPUL), "done_entry");
        run_row(mk(NOP, 16'h0000, 7, 16'h0000, F_DOFF), "done_blank");
        async_reset_check("reset_in_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
